// File: rtl/execute_stage_mc_if.sv
// Issue, forwarding and result bundle of the execute stage.
// The stage uses the slave modport; decode/testbench side uses master.
interface execute_stage_mc_if #(
    parameter int XLEN = 64
) ();
    logic            in_valid_i;
    logic            in_ready_o;
    logic [3:0]      op_i;
    logic [4:0]      rs1_i;
    logic [4:0]      rs2_i;
    logic [4:0]      rd_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic [XLEN-1:0] imm_i;
    logic            alu_src_i;
    logic            regwrite_i;
    logic [4:0]      rd_x_i;
    logic            regwrite_x_i;
    logic [XLEN-1:0] result_x_i;
    logic [4:0]      rd_w_i;
    logic            regwrite_w_i;
    logic [XLEN-1:0] result_w_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;
    logic            regwrite_o;
    logic            busy_o;
    logic            div_zero_o;

    modport slave (
        input  in_valid_i, op_i, rs1_i, rs2_i, rd_i,
        input  src1_i, src2_i, imm_i, alu_src_i, regwrite_i,
        input  rd_x_i, regwrite_x_i, result_x_i,
        input  rd_w_i, regwrite_w_i, result_w_i,
        input  out_ready_i,
        output in_ready_o, out_valid_o, result_o, rd_o,
        output regwrite_o, busy_o, div_zero_o
    );

    modport master (
        output in_valid_i, op_i, rs1_i, rs2_i, rd_i,
        output src1_i, src2_i, imm_i, alu_src_i, regwrite_i,
        output rd_x_i, regwrite_x_i, result_x_i,
        output rd_w_i, regwrite_w_i, result_w_i,
        output out_ready_i,
        input  in_ready_o, out_valid_o, result_o, rd_o,
        input  regwrite_o, busy_o, div_zero_o
    );
endinterface

// File: rtl/execute_stage_mc.sv
// Execute stage: forwarding, single-cycle ALU and an iterative
// shift-add multiplier / restoring divider behind one output register.
module execute_stage_mc #(
    parameter int XLEN      = 64,
    parameter bit MULDIV_EN = 1'b1
) (
    input logic               clk_i,
    input logic               reset_i,
    execute_stage_mc_if.slave bus
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [1:0] {M_MUL, M_DIVU, M_REMU} mop_e;

    state_e          state_q, state_d;
    mop_e            mop_q, mop_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [4:0]      mrd_q, mrd_d;
    logic            mrw_q, mrw_d;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_q, rd_d;
    logic            regwrite_q, regwrite_d;
    logic            dz_q, dz_d;

    logic [XLEN-1:0] op_a, op_b_fwd, op_b, alu_res;
    logic [SW-1:0]   shamt;
    logic [XLEN:0]   rem_sh, diff;
    logic            accept, is_md, ge;

    always_comb begin
        op_a = bus.src1_i;
        if (bus.regwrite_x_i && bus.rd_x_i == bus.rs1_i
            && bus.rs1_i != 5'd0)
            op_a = bus.result_x_i;
        else if (bus.regwrite_w_i && bus.rd_w_i == bus.rs1_i
                 && bus.rs1_i != 5'd0)
            op_a = bus.result_w_i;
        op_b_fwd = bus.src2_i;
        if (bus.regwrite_x_i && bus.rd_x_i == bus.rs2_i
            && bus.rs2_i != 5'd0)
            op_b_fwd = bus.result_x_i;
        else if (bus.regwrite_w_i && bus.rd_w_i == bus.rs2_i
                 && bus.rs2_i != 5'd0)
            op_b_fwd = bus.result_w_i;
        op_b = bus.alu_src_i ? bus.imm_i : op_b_fwd;
    end

    assign shamt  = op_b[SW-1:0];
    assign is_md  = MULDIV_EN && (bus.op_i >= 4'd10)
                    && (bus.op_i <= 4'd12);
    assign accept = bus.in_valid_i && bus.in_ready_o;

    assign bus.in_ready_o = (state_q == IDLE)
                            && (!out_valid_q || bus.out_ready_i);

    always_comb begin
        alu_res = '0;
        case (bus.op_i)
            4'd0: alu_res = op_a + op_b;
            4'd1: alu_res = op_a - op_b;
            4'd2: alu_res = op_a & op_b;
            4'd3: alu_res = op_a | op_b;
            4'd4: alu_res = op_a ^ op_b;
            4'd5: alu_res = {{(XLEN-1){1'b0}},
                             $signed(op_a) < $signed(op_b)};
            4'd6: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            4'd7: alu_res = op_a << shamt;
            4'd8: alu_res = op_a >> shamt;
            4'd9: alu_res = XLEN'($signed(op_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // Restoring step: remainder shifts in the next dividend bit from a_q.
    assign rem_sh = {acc_q, a_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, b_q};
    assign ge     = ~diff[XLEN];

    always_comb begin
        state_d     = state_q;
        mop_d       = mop_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        mrd_d       = mrd_q;
        mrw_d       = mrw_q;
        out_valid_d = out_valid_q & ~bus.out_ready_i;
        result_d    = result_q;
        rd_d        = rd_q;
        regwrite_d  = regwrite_q;
        dz_d        = dz_q;
        case (state_q)
            IDLE: begin
                if (accept && is_md) begin
                    state_d = BUSY;
                    a_d     = op_a;
                    b_d     = op_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    mrd_d   = bus.rd_i;
                    mrw_d   = bus.regwrite_i;
                    if (bus.op_i == 4'd10)      mop_d = M_MUL;
                    else if (bus.op_i == 4'd11) mop_d = M_DIVU;
                    else                        mop_d = M_REMU;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    result_d    = alu_res;
                    rd_d        = bus.rd_i;
                    regwrite_d  = bus.regwrite_i;
                    dz_d        = 1'b0;
                end
            end
            BUSY: begin
                if (mop_q == M_MUL) begin
                    acc_d = acc_q + (b_q[0] ? a_q : '0);
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    a_d   = {a_q[XLEN-2:0], ge};
                    acc_d = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
                end
                cnt_d = cnt_q + SW'(1);
                if (cnt_q == SW'(XLEN-1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                result_d    = (mop_q == M_DIVU) ? a_q : acc_q;
                rd_d        = mrd_q;
                regwrite_d  = mrw_q;
                dz_d        = (mop_q != M_MUL) && (b_q == '0);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            mop_q       <= M_MUL;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            mrd_q       <= '0;
            mrw_q       <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
            regwrite_q  <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mop_q       <= mop_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            mrd_q       <= mrd_d;
            mrw_q       <= mrw_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            regwrite_q  <= regwrite_d;
            dz_q        <= dz_d;
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.result_o    = result_q;
    assign bus.rd_o        = rd_q;
    assign bus.regwrite_o  = regwrite_q;
    assign bus.div_zero_o  = dz_q;
    assign bus.busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_execute_stage_mc.sv
// Testbench for execute_stage_mc: scenario tasks plus a
// scoreboard monitor that pops expected results on each handshake.
module tb_execute_stage_mc;
    localparam int XLEN = 64;
    typedef logic [XLEN-1:0] word_t;
    typedef struct packed {
        word_t      res;
        logic [4:0] rd;
        logic       rw;
        logic       dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    execute_stage_mc_if #(.XLEN(XLEN)) bus ();

    execute_stage_mc #(.XLEN(XLEN), .MULDIV_EN(1'b1)) dut (
        .clk_i  (clk),
        .reset_i(rst_n),
        .bus    (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    function automatic word_t model(logic [3:0] op, word_t a, word_t b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd6:  return (a < b) ? 64'd1 : 64'd0;
            4'd7:  return a << b[5:0];
            4'd8:  return a >> b[5:0];
            4'd9:  return word_t'($signed(a) >>> b[5:0]);
            4'd10: return a * b;
            4'd11: return (b == 0) ? {XLEN{1'b1}} : a / b;
            4'd12: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got %h, required none",
                         bus.result_o);
            end else begin
                mon_e = sb.pop_front();
                pops++;
                if ({bus.result_o, bus.rd_o, bus.regwrite_o,
                     bus.div_zero_o} !== mon_e) begin
                    errors++;
                    $display("FAIL scoreboard: got %h/%0d/%0b/%0b, required %h/%0d/%0b/%0b",
                             bus.result_o, bus.rd_o, bus.regwrite_o,
                             bus.div_zero_o, mon_e.res, mon_e.rd,
                             mon_e.rw, mon_e.dz);
                end
            end
        end
    end

    task automatic clear_fwd();
        bus.rd_x_i       = 5'd0;
        bus.regwrite_x_i = 1'b0;
        bus.result_x_i   = '0;
        bus.rd_w_i       = 5'd0;
        bus.regwrite_w_i = 1'b0;
        bus.result_w_i   = '0;
    endtask

    task automatic set_op(input logic [3:0] op, input word_t s1,
                          input word_t s2, input word_t imm,
                          input logic asrc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd);
        bus.op_i       = op;
        bus.src1_i     = s1;
        bus.src2_i     = s2;
        bus.imm_i      = imm;
        bus.alu_src_i  = asrc;
        bus.rs1_i      = rs1;
        bus.rs2_i      = rs2;
        bus.rd_i       = rd;
        bus.regwrite_i = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after acceptance.
    task automatic issue(input logic [3:0] op, input word_t s1,
                         input word_t s2, input word_t imm,
                         input logic asrc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input word_t er, input logic edz,
                         input bit push);
        int n;
        set_op(op, s1, s2, imm, asrc, rs1, rs2, rd);
        bus.in_valid_i = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready_o === 1'b1) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: in_ready_o=%b, required 1",
                         bus.in_ready_o);
                break;
            end
        end
        if (push) sb.push_back('{er, rd, 1'b1, edz});
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d, required 0",
                     sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_busy: got %b%b, required 00",
                     bus.out_valid_o, bus.busy_o);
        end
        checks++;
        if (bus.result_o !== '0) begin
            errors++;
            $display("FAIL reset_result: got %h, required 0", bus.result_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1", bus.in_ready_o);
        end
        checks++;
        if ({bus.rd_o, bus.regwrite_o, bus.div_zero_o} !== 7'd0) begin
            errors++;
            $display("FAIL reset_rd_rw_dz: got %h, required 0",
                     {bus.rd_o, bus.regwrite_o, bus.div_zero_o});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu();
        int    ops[12];
        word_t a, b;
        issue(4'd0, 64'd5, 64'd7, 64'd0, 1'b0, 5'd1, 5'd2, 5'd3,
              64'd12, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid_o !== 1'b1 || bus.result_o !== 64'd12) begin
            errors++;
            $display("FAIL add_latency: got v=%b r=%0d, required v=1 r=12",
                     bus.out_valid_o, bus.result_o);
        end
        issue(4'd5, -64'sd1, 64'd1, 64'd0, 1'b0, 5'd1, 5'd2, 5'd4,
              64'd1, 1'b0, 1'b1);
        issue(4'd6, -64'sd1, 64'd1, 64'd0, 1'b0, 5'd1, 5'd2, 5'd5,
              64'd0, 1'b0, 1'b1);
        issue(4'd7, 64'd1, 64'd67, 64'd0, 1'b0, 5'd1, 5'd2, 5'd6,
              64'd8, 1'b0, 1'b1);
        issue(4'd9, 64'h8000_0000_0000_0000, 64'd0, 64'd4, 1'b1,
              5'd1, 5'd2, 5'd7, 64'hF800_0000_0000_0000, 1'b0, 1'b1);
        issue(4'd0, 64'd40, 64'd999, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1,
              5'd1, 5'd2, 5'd8, 64'd38, 1'b0, 1'b1);
        ops = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 13, 14, 15};
        for (int i = 0; i < 12; i++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            issue(4'(ops[i]), a, b, 64'd0, 1'b0, 5'd1, 5'd2, 5'(i + 9),
                  model(4'(ops[i]), a, b), 1'b0, 1'b1);
        end
        drain();
    endtask

    task automatic test_forward();
        bus.rd_x_i       = 5'd3;
        bus.regwrite_x_i = 1'b1;
        bus.result_x_i   = 64'd100;
        bus.rd_w_i       = 5'd3;
        bus.regwrite_w_i = 1'b1;
        bus.result_w_i   = 64'd200;
        issue(4'd0, 64'd999, 64'd0, 64'd1, 1'b1, 5'd3, 5'd0, 5'd10,
              64'd101, 1'b0, 1'b1);
        bus.rd_x_i = 5'd0;
        bus.rd_w_i = 5'd0;
        issue(4'd0, 64'd77, 64'd0, 64'd1, 1'b1, 5'd0, 5'd0, 5'd11,
              64'd78, 1'b0, 1'b1);
        bus.rd_x_i     = 5'd9;
        bus.rd_w_i     = 5'd4;
        bus.result_w_i = 64'd50;
        issue(4'd0, 64'd5, 64'd999, 64'd0, 1'b0, 5'd1, 5'd4, 5'd12,
              64'd55, 1'b0, 1'b1);
        clear_fwd();
        drain();
    endtask

    task automatic test_mul();
        int    n;
        bit    bad;
        word_t a, b;
        bus.rd_x_i       = 5'd2;
        bus.regwrite_x_i = 1'b1;
        bus.result_x_i   = 64'd6;
        issue(4'd10, 64'd0, 64'd7, 64'd0, 1'b0, 5'd2, 5'd5, 5'd13,
              64'd42, 1'b0, 1'b1);
        bus.result_x_i = 64'd1000;
        n   = 0;
        bad = 1'b0;
        while (n < XLEN + 10) begin
            @(negedge clk);
            n++;
            if (bus.out_valid_o === 1'b1) break;
            if (bus.busy_o !== 1'b1 || bus.in_ready_o !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (n !== XLEN + 2) begin
            errors++;
            $display("FAIL mul_latency: got %0d, required %0d", n, XLEN + 2);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL mul_busy_ready: got bad=1, required busy=1 ready=0");
        end
        clear_fwd();
        @(posedge clk);
        #1;
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
        issue(4'd10, a, b, 64'd0, 1'b0, 5'd1, 5'd2, 5'd14,
              model(4'd10, a, b), 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_div();
        word_t a, b;
        issue(4'd11, 64'd10, 64'd0, 64'd0, 1'b0, 5'd1, 5'd2, 5'd15,
              {XLEN{1'b1}}, 1'b1, 1'b1);
        issue(4'd12, 64'd10, 64'd3, 64'd0, 1'b0, 5'd1, 5'd2, 5'd16,
              64'd1, 1'b0, 1'b1);
        issue(4'd12, 64'd1234, 64'd0, 64'd0, 1'b0, 5'd1, 5'd2, 5'd17,
              64'd1234, 1'b1, 1'b1);
        a = {$urandom(), $urandom()};
        b = {32'd0, $urandom()} | 64'd1;
        issue(4'd11, a, b, 64'd0, 1'b0, 5'd1, 5'd2, 5'd18,
              model(4'd11, a, b), 1'b0, 1'b1);
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()} >> 3;
        issue(4'd12, a, b, 64'd0, 1'b0, 5'd1, 5'd2, 5'd19,
              model(4'd12, a, b), 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_stall();
        bus.out_ready_i = 1'b0;
        issue(4'd0, 64'd20, 64'd22, 64'd0, 1'b0, 5'd1, 5'd2, 5'd7,
              64'd42, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid_o !== 1'b1 || bus.result_o !== 64'd42
                || bus.rd_o !== 5'd7 || bus.in_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: got v=%b r=%0d rd=%0d rdy=%b, required 1/42/7/0",
                         bus.out_valid_o, bus.result_o, bus.rd_o,
                         bus.in_ready_o);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        issue(4'd0, 64'd1, 64'd1, 64'd0, 1'b0, 5'd1, 5'd2, 5'd8,
              64'd2, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        int    p0, vcnt;
        word_t a, b;
        logic [3:0] op;
        p0   = pops;
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(0, 9));
            a  = {$urandom(), $urandom()};
            b  = {$urandom(), $urandom()};
            set_op(op, a, b, 64'd0, 1'b0, 5'd1, 5'd2, 5'(20 + i));
            bus.in_valid_i = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.in_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready: got %b, required 1", bus.in_ready_o);
            end
            if (i > 0 && bus.out_valid_o === 1'b1) vcnt++;
            sb.push_back('{model(op, a, b), 5'(20 + i), 1'b1, 1'b0});
            @(posedge clk);
            #1;
        end
        bus.in_valid_i = 1'b0;
        drain();
        checks++;
        if (vcnt !== 7 || pops - p0 !== 8) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d/%0d, required 7/8",
                     vcnt, pops - p0);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        issue(4'd11, 64'd1000, 64'd3, 64'd0, 1'b0, 5'd1, 5'd2, 5'd9,
              64'd0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid_o, bus.busy_o, bus.div_zero_o,
             bus.regwrite_o} !== 4'd0) begin
            errors++;
            $display("FAIL midreset_flags: got %b, required 0000",
                     {bus.out_valid_o, bus.busy_o, bus.div_zero_o,
                      bus.regwrite_o});
        end
        checks++;
        if (bus.result_o !== '0 || bus.rd_o !== 5'd0) begin
            errors++;
            $display("FAIL midreset_data: got %h/%0d, required 0/0",
                     bus.result_o, bus.rd_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < XLEN + 6; i++) begin
            @(negedge clk);
            if (bus.out_valid_o === 1'b1 || bus.busy_o === 1'b1)
                seen = 1'b1;
        end
        checks++;
        if (seen || bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_noresult: got seen=%b rdy=%b, required 0/1",
                     seen, bus.in_ready_o);
        end
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        set_op(4'd0, '0, '0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
        clear_fwd();
        test_reset();
        test_alu();
        test_forward();
        test_mul();
        test_div();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL final_queue: got %0d, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_stage_mc.md
EXECUTE_STAGE_MC -- requirements
Module: execute_stage_mc

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width in bits (power of two, 32 or 64).
REQ-002 SHALL have parameter MULDIV_EN, default 1, enabling the iterative multiply/divide unit.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid_i, input, 1, issue request from decode.
REQ-006 SHALL have port in_ready_o, output, 1, stage can accept an issue.
REQ-007 SHALL have port op_i, input, 4, operation code.
REQ-008 SHALL have ports rs1_i, rs2_i, rd_i, input, 5 each, source and destination register indices.
REQ-009 SHALL have ports src1_i, src2_i, imm_i, input, XLEN each, register-file operands and sign-extended immediate.
REQ-010 SHALL have ports alu_src_i and regwrite_i, input, 1 each: operand B selects imm_i when alu_src_i=1; instruction writes rd.
REQ-011 SHALL have ports rd_x_i (5), regwrite_x_i (1), result_x_i (XLEN), inputs, memory-stage forwarding source.
REQ-012 SHALL have ports rd_w_i (5), regwrite_w_i (1), result_w_i (XLEN), inputs, writeback-stage forwarding source.
REQ-013 SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1), downstream handshake.
REQ-014 SHALL have ports result_o (XLEN), rd_o (5), regwrite_o (1), outputs, registered result bundle.
REQ-015 SHALL have ports busy_o and div_zero_o, outputs, 1 each: multi-cycle op in progress; held result came from division by zero.

Function
REQ-016 SHALL accept an issue on a cycle with in_valid_i=1 and in_ready_o=1; in_ready_o = (state==IDLE) and (out_valid_o=0 or out_ready_i=1).
REQ-017 SHALL forward operand A: result_x_i if regwrite_x_i and rd_x_i==rs1_i!=0; else result_w_i if regwrite_w_i and rd_w_i==rs1_i!=0; else src1_i. Operand B is forwarded likewise before the alu_src_i mux.
REQ-018 SHALL latch forwarded operands, rd_i, regwrite_i and op_i at acceptance; later changes to forwarding inputs have no effect.
REQ-019 SHALL use op codes 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11 DIVU, 12 REMU; codes 13-15 produce result 0 with single-cycle latency.
REQ-020 SHALL use only the low log2(XLEN) bits of operand B as shift amount; arithmetic wraps modulo 2^XLEN; SLT/SLTU return 0 or 1.
REQ-021 SHALL, for single-cycle ops, present result with out_valid_o=1 on the cycle after acceptance (latency 1).
REQ-022 SHALL implement FSM IDLE -> BUSY on accepting op 10-12 (MULDIV_EN=1), BUSY -> DONE after exactly XLEN iteration cycles, DONE -> IDLE when the result is loaded to the output register (one cycle); multi-cycle latency XLEN+2, busy_o=1 in BUSY and DONE.
REQ-023 SHALL compute MUL as low XLEN bits of the unsigned product by shift-add, DIVU/REMU by restoring division, one bit per cycle, with a 0..XLEN-1 iteration counter.
REQ-024 SHALL, on DIVU/REMU with divisor 0, return quotient all-ones or remainder = dividend, and set div_zero_o=1 for that result only.
REQ-025 SHALL, with MULDIV_EN=0, treat ops 10-12 as single-cycle with result 0 and never leave IDLE.
REQ-026 SHALL hold result_o, rd_o, regwrite_o, div_zero_o stable while out_valid_o=1 and out_ready_i=0; out_valid_o clears after a handshake with no new result loading that cycle.
REQ-027 SHALL sustain one single-cycle op per cycle when out_ready_i stays 1 (back-to-back accept and drain).

Reset
REQ-028 SHALL, while reset_i=0, immediately force state IDLE, counter 0, out_valid_o=0, busy_o=0, div_zero_o=0, result_o=0, rd_o=0, regwrite_o=0, including mid-operation; in_ready_o=1 after release.
REQ-029 SHALL discard any in-progress multi-cycle op on reset and produce no result for it.

Verification
REQ-030 SHALL cover: XLEN=64, ADD src1=5, src2=7 -> next cycle out_valid_o=1, result_o=12.
REQ-031 SHALL cover: rs1=3, rd_x_i=3 with result_x_i=100, rd_w_i=3 with result_w_i=200, both regwrites, ADDI imm=1 -> result_o=101; rs1=0 with rd_x_i=0 -> src1_i used.
REQ-032 SHALL cover: MUL 6x7 -> busy_o high, out_valid_o exactly XLEN+2 cycles after accept with result 42; in_ready_o=0 throughout.
REQ-033 SHALL cover: DIVU 10/0 -> result all-ones, div_zero_o=1; REMU 10/3 -> 1, div_zero_o=0.
REQ-034 SHALL cover: out_ready_i=0 for 3 cycles with valid result -> outputs stable, in_ready_o=0; release -> drains, next op accepted.
REQ-035 SHALL cover: reset_i asserted at DIVU iteration 10 -> all outputs 0 immediately, no result after release.
